// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared geometry and FSM state encoding for cache and cache_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int TAG_W          = 5;
    localparam int INDEX_W        = 8;
    localparam int WORD_W         = 2;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 15;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMP  = 3'd1,
        ST_WB   = 3'd2,
        ST_FILL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Write-back, write-allocate controller for a direct-mapped cache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_ready,
    output logic                cpu_done,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_hit,
    output logic                c_enable,
    output logic                c_comp,
    output logic                c_write,
    output logic                c_valid_in,
    output logic [INDEX_W-1:0]  c_index,
    output logic [WORD_W-1:0]   c_word,
    output logic [TAG_W-1:0]    c_tag_in,
    output logic [DATA_W-1:0]   c_data_in,
    input  logic                c_hit,
    input  logic                c_dirty,
    input  logic                c_valid,
    input  logic [TAG_W-1:0]    c_tag_out,
    input  logic [DATA_W-1:0]   c_data_out,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    state_t              r_state;
    logic                r_req_we;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [TAG_W-1:0]    r_victim_tag;
    logic [WORD_W-1:0]   r_word;
    logic                r_missed;
    logic                r_cpu_done;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic                r_cpu_hit;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [TAG_W-1:0]    w_req_tag;
    logic [INDEX_W-1:0]  w_req_index;
    logic [WORD_W-1:0]   w_req_word;
    logic                w_hit;
    logic                w_last;

    assign w_req_tag   = r_req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_index = r_req_addr[WORD_W +: INDEX_W];
    assign w_req_word  = r_req_addr[WORD_W-1:0];
    assign w_hit       = c_hit & c_valid;
    assign w_last      = (r_word == WORD_W'(WORDS_PER_LINE - 1));

    assign cpu_ready = (r_state == ST_IDLE);
    assign cpu_done  = r_cpu_done;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_hit   = r_cpu_hit;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    // Array/memory strobes decode straight from state so reset drops them at once.
    always_comb begin
        c_enable   = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_index    = '0;
        c_word     = '0;
        c_tag_in   = '0;
        c_data_in  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            ST_CMP: begin
                c_enable  = 1'b1;
                c_comp    = 1'b1;
                c_write   = r_req_we;
                c_index   = w_req_index;
                c_word    = w_req_word;
                c_tag_in  = w_req_tag;
                c_data_in = r_req_wdata;
            end
            ST_WB: begin
                c_enable  = 1'b1;
                c_index   = w_req_index;
                c_word    = r_word;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_victim_tag, w_req_index, r_word};
                mem_wdata = c_data_out;
            end
            ST_FILL: begin
                c_enable   = mem_ack;
                c_write    = mem_ack;
                c_valid_in = 1'b1;
                c_index    = w_req_index;
                c_word     = r_word;
                c_tag_in   = w_req_tag;
                c_data_in  = mem_rdata;
                mem_req    = 1'b1;
                mem_addr   = {w_req_tag, w_req_index, r_word};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_victim_tag <= '0;
            r_word       <= '0;
            r_missed     <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_hit    <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_req_we    <= cpu_we;
                        r_req_addr  <= cpu_addr;
                        r_req_wdata <= cpu_wdata;
                        r_state     <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (w_hit) begin
                        r_cpu_rdata <= c_data_out;
                        r_cpu_hit   <= ~r_missed;
                        r_cpu_done  <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_missed <= 1'b1;
                        r_word   <= '0;
                        if (c_valid && c_dirty) begin
                            r_victim_tag <= c_tag_out;
                            r_state      <= ST_WB;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        r_word <= r_word + 2'd1;
                        if (w_last) r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Replaying the compare after the last word turns the miss into a hit.
                    if (mem_ack) begin
                        r_word <= r_word + 2'd1;
                        if (w_last) r_state <= ST_CMP;
                    end
                end
                ST_DONE: begin
                    r_cpu_done <= 1'b0;
                    r_missed   <= 1'b0;
                    if (r_missed) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    else          r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
# cache_ctrl

- Initiator-side controller for the 256-line × 4-word direct-mapped `cache` array.
- Accepts single-word CPU loads and stores and drives the array's enable/index/word/comp/write/tag/data/valid port.
- On a miss, it writes back a dirty victim line and refills the 4-word line from the next-level memory over a req/ack word handshake.
- Sits between the CPU memory stage and the `cache` array plus the memory model.

## Interface
Parameters:
- CNT_W, 16, width of the hit and miss statistic counters.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe, sampled only while cpu_ready=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  15  word address {tag[4:0], index[7:0], word[1:0]}.
- cpu_wdata  in  16  store data.
- cpu_ready  out  1  controller idle, can accept a request.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  load data, valid while cpu_done=1.
- cpu_hit  out  1  with cpu_done: 1 if the first compare hit.
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache array controls.
- c_index  out  8  cache array index.
- c_word  out  2  cache array word select.
- c_tag_in  out  5  cache array tag input.
- c_data_in  out  16  cache array data input.
- c_hit, c_dirty, c_valid  in  1 each  cache array status outputs.
- c_tag_out  in  5  cache array tag output.
- c_data_out  in  16  cache array data output.
- mem_req  out  1  memory word transaction request.
- mem_we  out  1  1 = memory write, 0 = memory read.
- mem_addr  out  15  memory word address.
- mem_wdata  out  16  memory write data.
- mem_ack  in  1  memory acknowledge.
- mem_rdata  in  16  memory read data, valid with mem_ack.
- hit_cnt, miss_cnt  out  CNT_W each  statistic counters.

## Operation
**Cache array behaviour relied on:**
- c_* outputs respond combinationally within the cycle.
- Writes commit at the rising edge where c_enable & c_write.
- comp=1 write=1 sets dirty.
- comp=0 write=1 writes data, tag and valid, and clears dirty.

**States:** IDLE, CMP, WB, FILL, DONE.

**IDLE**
- cpu_ready=1.
- When cpu_req=1, latch we/addr/wdata into req_* and go to CMP.

**CMP**
- Drive c_enable=1, c_comp=1, c_write=req_we, c_index/c_word/c_tag_in from req_addr, c_data_in=req_wdata.
- Hit (c_hit & c_valid): latch c_data_out into cpu_rdata; store commits this edge; go to DONE.
- Miss with c_valid & c_dirty: latch victim tag = c_tag_out, clear word counter, go to WB.
- Miss otherwise: clear word counter, go to FILL.
- A miss sets the sticky flag `missed`.

**WB**
- Per word k = 0..3: drive a cache read (enable=1, comp=0, write=0, word=k).
- mem_req=1, mem_we=1, mem_addr={victim_tag, index, k}, mem_wdata=c_data_out.
- On the edge where mem_ack=1, k increments.
- After k=3 is acked: clear k, go to FILL.

**FILL**
- Per word k = 0..3: mem_req=1, mem_we=0, mem_addr={req_tag, index, k}.
- On the edge where mem_ack=1: write the cache with comp=0, write=1, valid_in=1, tag_in=req_tag, data_in=mem_rdata, word=k.
- After k=3: go back to CMP (replay, which must hit).
- Write-allocate: a store miss fills the line, then the replay performs the store.

**DONE**
- cpu_done=1, cpu_hit=~missed; clear `missed`; go to IDLE.

**Counters and defaults:**
- hit_cnt increments in DONE when missed=0; miss_cnt increments in DONE when missed=1.
- Both counters wrap modulo 2^CNT_W.
- Outside the active state, all c_* and mem_* outputs are 0.

## Timing
**Reset:**
- cpu_ready=1.
- Zero on reset: cpu_done, cpu_rdata, cpu_hit, all c_*, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt, word counter, missed.
- State = IDLE.

**Latency:**
- Hit: cpu_req sampled at edge 0, CMP in cycle 1, cpu_done high in cycle 2, cpu_ready high in cycle 3.
- Miss: each word costs ≥1 cycle (1 if mem_ack is already high).

**Memory handshake:**
- mem_addr and mem_wdata stay stable while mem_req=1 and mem_ack=0.
- Back-to-back words: mem_req stays high and the address advances the cycle after ack.
- mem_req drops the cycle after the last ack.
- mem_ack while mem_req=0 is ignored.

**Other rules:**
- cpu_req while cpu_ready=0 is ignored, with no queueing.
- Word counter is 2 bits and wraps 3→0 exactly as it leaves WB or FILL.
- rst asserted mid-WB or mid-FILL forces IDLE immediately.
  - mem_req drops asynchronously.
  - A partially filled line may remain valid with mixed data; this is accepted.

## Structure
- Package `cache_pkg`, shared with `cache`:
  - state encoding.
  - TAG_W=5, INDEX_W=8, WORD_W=2, DATA_W=16, ADDR_W=15.
  - WORDS_PER_LINE=4.
- Single module; no sub-module. The FSM and the datapath registers are small.
- Bench instantiates `cache_ctrl` + `cache` + a memory model with a programmable ack delay.

## Test plan
1. After reset, load 0x1234 into memory at 0x0A05. Read 0x0A05: cold miss, 4 mem reads to 0x0A04..0x0A07, then cpu_rdata=0x1234, cpu_hit=0, miss_cnt=1.
2. Read 0x0A05 again: cpu_done exactly 2 cycles after cpu_req, cpu_hit=1, zero mem_req cycles, hit_cnt=1.
3. Write 0xBEEF to 0x0A06 (hit, line dirty). Then read 0x4A06 (same index, tag 0x12): 4 mem writes to 0x0A04..0x0A07, word 2 = 0xBEEF, then 4 reads from 0x4A04..0x4A07.
4. Write miss to 0x1000 with a clean victim: fill only, no WB. Replay store hits; a later read returns the stored value, cpu_hit=1.
5. Memory ack delay of 3 cycles: mem_addr held stable 4 cycles per word. Total miss cycles = 16 + the CMP/DONE overhead.
6. rst pulled low during FILL word 2: the same cycle shows mem_req=0, cpu_ready=1, counters=0. A following read to the same address refills and returns the correct data.
